// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target register block.
package spi_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } spi_state_e;

    localparam int CMD_RW_BIT = 7;
    localparam int BYTE_BITS  = 8;
    localparam int BIT_CNT_W  = $clog2(BYTE_BITS);

    localparam logic [7:0] RD_EMPTY = 8'hFF;

    function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
        return cnt == BIT_CNT_W'(BYTE_BITS - 1);
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// Multi-stage synchroniser for one asynchronous SPI input, with rise/fall pulses
// derived from the synchronised level.
module spi_target_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   q_d;

    // Deliberately not reset: the chain keeps tracking the pin through a reset, so
    // releasing reset never fabricates an edge on a line that was already high.
    always_ff @(posedge clk) begin
        chain <= {chain[SYNC_STAGES-2:0], d};
        q_d   <= chain[SYNC_STAGES-1];
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_target_regs.sv
// SPI target: decodes MSB-first command/data frames into a local register file and
// offers a host port. Build option: SPI_TARGET_ADDR_INC_EN (address auto-increment).
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | no frame; waits for an armed SPI_EN rise
//  ST_CMD   | shifting in the command byte on SPI_CLK rises
//  ST_WDATA | shifting in write data on rises; each full byte commits
//  ST_RDATA | shifting out read data on falls; each full byte reloads
module spi_target_regs
    import spi_target_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPI_CLK,
    input  logic              SPI_EN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_act,
    output logic              frame_err
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic en_lvl, en_rise, en_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic sync_unused;

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk  (clk),
        .d    (SPI_CLK),
        .q    (sclk_lvl),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
        .clk  (clk),
        .d    (SPI_EN),
        .q    (en_lvl),
        .rise (en_rise),
        .fall (en_fall)
    );

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk  (clk),
        .d    (SPI_MOSI),
        .q    (mosi_lvl),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    assign sync_unused = ^{sclk_lvl, mosi_rise, mosi_fall};

    spi_state_e             state, state_nxt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [7:0]             shift;
    logic [7:0]             shift_in;
    logic [ADDR_W-1:0]      addr;
    logic [ADDR_W-1:0]      addr_step;
    logic [ADDR_W-1:0]      cmd_addr;
    logic                   armed;
    logic                   frame_stop;
    logic                   byte_done;
    logic [7:0]             regs [NUM_REGS];

    assign shift_in = {shift[6:0], mosi_lvl};
    assign cmd_addr = shift_in[ADDR_W-1:0];

`ifdef SPI_TARGET_ADDR_INC_EN
    assign addr_step = addr + ADDR_W'(1);
`else
    assign addr_step = addr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_stop = 1'b0;
        byte_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (armed && en_rise) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (en_fall) begin
                    state_nxt  = ST_IDLE;
                    frame_stop = 1'b1;
                end else if (sclk_rise && is_last_bit(bit_cnt)) begin
                    byte_done = 1'b1;
                    state_nxt = shift_in[CMD_RW_BIT] ? ST_RDATA : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (en_fall) begin
                    state_nxt  = ST_IDLE;
                    frame_stop = 1'b1;
                end else if (sclk_rise && is_last_bit(bit_cnt)) begin
                    byte_done = 1'b1;
                end
            end
            ST_RDATA: begin
                if (en_fall) begin
                    state_nxt  = ST_IDLE;
                    frame_stop = 1'b1;
                end else if (sclk_fall && is_last_bit(bit_cnt)) begin
                    byte_done = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift      <= '0;
            addr       <= '0;
            armed      <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
            host_rdata <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= frame_stop && (bit_cnt != '0);
            if (!en_lvl) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_CMD) begin
                        bit_cnt <= '0;
                    end
                end
                ST_CMD: begin
                    if (!en_fall && sclk_rise) begin
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        shift   <= shift_in;
                        if (byte_done) begin
                            addr <= cmd_addr;
                            if (shift_in[CMD_RW_BIT]) begin
                                shift <= regs[cmd_addr];
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (!en_fall && sclk_rise) begin
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        shift   <= shift_in;
                        if (byte_done) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                            wr_data   <= shift_in;
                            addr      <= addr_step;
                        end
                    end
                end
                ST_RDATA: begin
                    if (!en_fall && sclk_fall) begin
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        shift   <= {shift[6:0], 1'b0};
                        if (byte_done) begin
                            addr  <= addr_step;
                            shift <= regs[addr_step];
                        end
                    end
                end
                default: ;
            endcase

            // The SPI commit lands in the strobe cycle and beats a same-address host write.
            if (host_we && !(wr_strobe && (host_addr == wr_addr))) begin
                regs[host_addr] <= host_wdata;
            end
            if (wr_strobe) begin
                regs[wr_addr] <= wr_data;
            end
            host_rdata <= regs[host_addr];
        end
    end

    assign SPI_MISO  = (state == ST_RDATA) & shift[7];
    assign frame_act = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_target_regs.sv
// Randomized frame-level bench for spi_target_regs against an array/queue model.
module tb_spi_target_regs;

    localparam int NREG = 16;
`ifdef SPI_TARGET_ADDR_INC_EN
    localparam bit INC = 1'b1;
`else
    localparam bit INC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk, spi_en, spi_mosi, spi_miso;
    logic       host_we;
    logic [3:0] host_addr, wr_addr;
    logic [7:0] host_wdata, host_rdata, wr_data;
    logic       wr_strobe, frame_act, frame_err;

    always #5 clk = ~clk;

    spi_target_regs #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .SPI_CLK    (spi_clk),
        .SPI_EN     (spi_en),
        .SPI_MOSI   (spi_mosi),
        .SPI_MISO   (spi_miso),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_act  (frame_act),
        .frame_err  (frame_err)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         err_seen = 0;
    bit         miso_zero_exp = 1'b1;
    logic [7:0] mem [NREG];
    wr_t        exp_q [$];
    logic [3:0] last_wr_addr;
    logic [7:0] last_wr_data;
    logic [7:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model: commits, error pulses, idle MISO.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b0) begin
                if (wr_strobe === 1'b1) begin
                    last_wr_addr = wr_addr;
                    last_wr_data = wr_data;
                    if (exp_q.size() == 0) begin
                        check("wr_strobe_unexpected", wr_strobe, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", wr_addr, e.a);
                        check("wr_data", wr_data, e.d);
                    end
                end
                if (frame_err === 1'b1) err_seen++;
                if (miso_zero_exp) check("miso_idle", spi_miso, 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_fall(input logic b, output logic smp);
        smp      = spi_miso;
        spi_clk  = 1'b0;
        spi_mosi = b;
        wait_cyc(4);
    endtask

    task automatic spi_rise();
        spi_clk = 1'b1;
        wait_cyc(4);
    endtask

    // Sends the top nbits of b; a full write byte is queued for commit before its last rise.
    task automatic send_byte(input logic [7:0] b, input int nbits, input bit push_wr,
                             input logic [3:0] a, input bit rd_entry, output logic [7:0] rd);
        for (int i = 7; i > 7 - nbits; i--) begin
            logic s;
            spi_fall(b[i], s);
            rd[i] = s;
            if (i == 0 && push_wr) begin
                exp_q.push_back({a, b});
                mem[a] = b;
            end
            if (i == 0 && rd_entry) miso_zero_exp = 1'b0;
            spi_rise();
        end
    endtask

    task automatic frame_begin();
        spi_en = 1'b1;
        wait_cyc(4);
        check("frame_act_start", frame_act, 1);
    endtask

    task automatic frame_end(input int exp_err, input int e0);
        spi_en = 1'b0;
        wait_cyc(6);
        check("frame_err_count", err_seen - e0, exp_err);
        check("frame_act_idle", frame_act, 0);
        check("spi_miso_after_frame", spi_miso, 0);
        check("commits_drained", exp_q.size(), 0);
        miso_zero_exp = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] data [$], input int partial);
        logic [3:0] a;
        logic [7:0] rd;
        bit         is_rd;
        int         e0;
        a     = cmd[3:0];
        is_rd = cmd[7];
        e0    = err_seen;
        frame_begin();
        send_byte(cmd, 8, 1'b0, 4'd0, is_rd, rd);
        foreach (data[i]) begin
            if (is_rd) begin
                send_byte(8'h00, 8, 1'b0, 4'd0, 1'b0, rd);
                last_rd = rd;
                check("read_byte", rd, mem[a]);
            end else begin
                send_byte(data[i], 8, 1'b1, a, 1'b0, rd);
            end
            if (INC) a = a + 4'd1;
        end
        if (partial > 0) send_byte(8'($urandom_range(0, 255)), partial, 1'b0, 4'd0, 1'b0, rd);
        frame_end((partial > 0) ? 1 : 0, e0);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        wait_cyc(1);
        host_we    = 1'b0;
        mem[a]     = d;
    endtask

    task automatic host_read(input string name, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        wait_cyc(2);
        check(name, host_rdata, exp);
    endtask

    task automatic dump_check();
        for (int i = 0; i < NREG; i++) host_read("regfile", 4'(i), mem[i]);
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] rd;
        logic       s;
        bit         got;
        int         e0;

        rst = 1'b1; spi_en = 1'b0; spi_clk = 1'b1; spi_mosi = 1'b0;
        host_we = 1'b0; host_addr = 4'd0; host_wdata = 8'd0;
        for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
        wait_cyc(5);
        check("rst_frame_act", frame_act, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_miso", spi_miso, 0);
        check("rst_host_rdata", host_rdata, 0);
        rst = 1'b0;
        wait_cyc(6);
        dump_check();

        // 1: single write
        q = '{8'hA5};
        do_frame(8'h03, q, 0);
        check("t1_wr_addr_literal", last_wr_addr, 4'd3);
        check("t1_wr_data_literal", last_wr_data, 8'hA5);
        host_read("t1_reg3", 4'd3, 8'hA5);

        // 2: host write then SPI read
        host_write(4'd5, 8'h3C);
        q = '{8'h00};
        do_frame(8'h85, q, 0);
        check("t2_read_literal", last_rd, 8'h3C);

        // 3: write burst at the top of the address space
        q = '{8'h11, 8'h22};
        do_frame(8'h0F, q, 0);
`ifdef SPI_TARGET_ADDR_INC_EN
        host_read("t3_reg15", 4'd15, 8'h11);
        host_read("t3_reg0", 4'd0, 8'h22);
`else
        host_read("t3_reg15", 4'd15, 8'h22);
`endif

        // 4: abort after 5 data bits
        q.delete();
        do_frame(8'h07, q, 5);
        dump_check();

        // 5: host write colliding with an SPI commit
        e0 = err_seen;
        frame_begin();
        send_byte(8'h03, 8, 1'b0, 4'd0, 1'b0, rd);
        send_byte(8'h99, 7, 1'b0, 4'd0, 1'b0, rd);
        spi_fall(1'b1, s);
        exp_q.push_back({4'd3, 8'h99});
        mem[3] = 8'h99;
        spi_clk = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (wr_strobe === 1'b1) got = 1'b1;
        end
        check("t5_strobe_seen", got, 1);
        host_addr  = 4'd3;
        host_wdata = 8'h55;
        host_we    = 1'b1;
        wait_cyc(1);
        host_we    = 1'b0;
        wait_cyc(3);
        frame_end(0, e0);
        host_read("t5_reg3", 4'd3, 8'h99);

        // 6: reset mid-byte with SPI_EN held high
        frame_begin();
        send_byte(8'h03, 8, 1'b0, 4'd0, 1'b0, rd);
        send_byte(8'hF0, 3, 1'b0, 4'd0, 1'b0, rd);
        rst = 1'b1;
        wait_cyc(2);
        check("t6_rst_frame_act", frame_act, 0);
        check("t6_rst_wr_strobe", wr_strobe, 0);
        check("t6_rst_frame_err", frame_err, 0);
        check("t6_rst_miso", spi_miso, 0);
        check("t6_rst_host_rdata", host_rdata, 0);
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
        e0 = err_seen;
        for (int i = 4; i >= 0; i--) begin
            spi_fall(1'b1, s);
            spi_rise();
        end
        check("t6_ignored_frame_act", frame_act, 0);
        frame_end(0, e0);
        dump_check();
        q = '{8'h5A};
        do_frame(8'h03, q, 0);
        host_read("t6_reg3", 4'd3, 8'h5A);

        // Randomized frames interleaved with host writes
        for (int f = 0; f < 40; f++) begin
            logic [7:0] cmd;
            int         n, partial, nh;
            nh = $urandom_range(0, 2);
            for (int h = 0; h < nh; h++) host_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            cmd = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            q.delete();
            n = $urandom_range(1, 3);
            for (int b = 0; b < n; b++) q.push_back(8'($urandom_range(0, 255)));
            partial = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            do_frame(cmd, q, partial);
            wait_cyc(4);
        end
        dump_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
